// File: rtl/k_cpu_pkg.sv
// k_cpu_pkg: shared definitions for the K CPU front end.
//   - fetch_state_e : fetch FSM states (IDLE, RUN, HALT)
//   - IMEM_DEPTH    : instruction memory depth in words (power of two)
//   - XLEN          : datapath width
//   - K_NOP         : the all-zero instruction word (halt marker when
//                     K_FETCH_HALT_EN is defined)
package k_cpu_pkg;

    localparam int IMEM_DEPTH = 1024;
    localparam int XLEN       = 32;

    localparam logic [XLEN-1:0] K_NOP = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/k_fetch_unit_if.sv
// k_fetch_unit_if: fetch-to-decode valid/ready handshake.
//   out_valid : fetch -> decode, out_instr/out_pc hold a valid word
//   out_ready : decode -> fetch, decode accepts when both are high
//   out_instr : fetched instruction
//   out_pc    : word address of out_instr, zero-extended
// Modports: master (fetch side), slave (decode side).
interface k_fetch_unit_if;
    import k_cpu_pkg::*;

    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_instr;
    logic [XLEN-1:0] out_pc;

    modport master (
        output out_valid,
        output out_instr,
        output out_pc,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_instr,
        input  out_pc,
        output out_ready
    );

endinterface

// File: rtl/k_fetch_out_reg.sv
// k_fetch_out_reg: single-entry valid/ready output register with flush.
//   clk, reset        : clock, asynchronous active-high reset
//   flush             : drop the held word (valid cleared), highest priority
//   load              : capture load_instr/load_pc and mark valid
//   ready             : consumer accepts the held word when valid
//   valid, instr, pc  : registered slot contents
// The caller only asserts load when the slot is free (!valid || ready).
module k_fetch_out_reg
    import k_cpu_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            load,
    input  logic            ready,
    input  logic [XLEN-1:0] load_instr,
    input  logic [XLEN-1:0] load_pc,
    output logic            valid,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] pc
);

    logic            valid_r;
    logic [XLEN-1:0] instr_r;
    logic [XLEN-1:0] pc_r;

    // Slot state: flush beats load, load beats drain, otherwise hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_r <= 1'b0;
            instr_r <= 32'h0000_0000;
            pc_r    <= 32'h0000_0000;
        end else if (flush) begin
            valid_r <= 1'b0;
        end else if (load) begin
            valid_r <= 1'b1;
            instr_r <= load_instr;
            pc_r    <= load_pc;
        end else if (valid_r && ready) begin
            valid_r <= 1'b0;
        end else begin
            valid_r <= valid_r;
        end
    end

    assign valid = valid_r;
    assign instr = instr_r;
    assign pc    = pc_r;

endmodule

// File: rtl/k_fetch_unit.sv
// k_fetch_unit: program counter and fetch stage in front of a
// combinational instruction memory.
//   clk, reset     : clock, asynchronous active-high reset
//   start          : one-cycle pulse, IDLE -> RUN
//   redirect_valid : load redirect_pc (low PC_W bits) this cycle, flushes
//   redirect_pc    : new word address
//   imem_addr      : word address to memory (zero-extended pc)
//   imem_instr     : combinational memory data for imem_addr
//   dec            : k_fetch_unit_if.master handshake towards decode
//   running        : FSM in RUN
//   halted         : FSM in HALT (tied 0 unless K_FETCH_HALT_EN)
//   fetch_count    : accepted instructions, saturating
// Optional feature macro: K_FETCH_HALT_EN -- a fetched all-zero word is
// not issued; the FSM halts with pc pointing at it until a redirect.
module k_fetch_unit
    import k_cpu_pkg::*;
#(
    parameter int IMEM_DEPTH = k_cpu_pkg::IMEM_DEPTH,
    parameter int PC_W       = $clog2(IMEM_DEPTH),
    parameter int RESET_PC   = 0,
    parameter int CNT_W      = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              redirect_valid,
    input  logic [XLEN-1:0]   redirect_pc,
    output logic [XLEN-1:0]   imem_addr,
    input  logic [XLEN-1:0]   imem_instr,
    k_fetch_unit_if.master    dec,
    output logic              running,
    output logic              halted,
    output logic [CNT_W-1:0]  fetch_count
);

    fetch_state_e     state_r;
    logic [PC_W-1:0]  pc_r;
    logic             running_r;
    logic [CNT_W-1:0] cnt_r;
    logic             out_valid_s;
    logic             slot_free_s;
    logic             fetch_s;
    logic             halt_hit_s;
    logic             load_s;
    logic             unused_s;

    // Only the low PC_W bits of a redirect target are meaningful.
    assign unused_s    = ^redirect_pc[XLEN-1:PC_W];

    assign imem_addr   = {{(XLEN-PC_W){1'b0}}, pc_r};
    assign slot_free_s = !out_valid_s || dec.out_ready;
    assign fetch_s     = (state_r == ST_RUN) && slot_free_s && !redirect_valid;

`ifdef K_FETCH_HALT_EN
    logic halted_r;
    // A zero word is swallowed instead of being issued.
    assign halt_hit_s = fetch_s && (imem_instr == K_NOP);
    assign halted     = halted_r;
`else
    assign halt_hit_s = 1'b0;
    assign halted     = 1'b0;
`endif

    assign load_s = fetch_s && !halt_hit_s;

    // PC and fetch FSM; redirect wins over start, fetch and stall.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            pc_r      <= PC_W'(RESET_PC);
            running_r <= 1'b0;
`ifdef K_FETCH_HALT_EN
            halted_r  <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (redirect_valid) begin
                        pc_r <= redirect_pc[PC_W-1:0];
                    end else if (start) begin
                        state_r   <= ST_RUN;
                        running_r <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (redirect_valid) begin
                        pc_r <= redirect_pc[PC_W-1:0];
`ifdef K_FETCH_HALT_EN
                    end else if (halt_hit_s) begin
                        // pc stays on the zero word
                        state_r   <= ST_HALT;
                        running_r <= 1'b0;
                        halted_r  <= 1'b1;
`endif
                    end else if (fetch_s) begin
                        pc_r <= pc_r + PC_W'(1);   // wraps modulo IMEM_DEPTH
                    end else begin
                        pc_r <= pc_r;
                    end
                end
`ifdef K_FETCH_HALT_EN
                ST_HALT: begin
                    if (redirect_valid) begin
                        pc_r      <= redirect_pc[PC_W-1:0];
                        state_r   <= ST_RUN;
                        running_r <= 1'b1;
                        halted_r  <= 1'b0;
                    end else begin
                        state_r <= ST_HALT;
                    end
                end
`endif
                default: begin
                    state_r   <= ST_IDLE;
                    running_r <= 1'b0;
`ifdef K_FETCH_HALT_EN
                    halted_r  <= 1'b0;
`endif
                end
            endcase
        end
    end

    // Handshake counter, sticks at all-ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r <= '0;
        end else if (out_valid_s && dec.out_ready && (cnt_r != {CNT_W{1'b1}})) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    k_fetch_out_reg u_out_reg (
        .clk        (clk),
        .reset      (reset),
        .flush      (redirect_valid),
        .load       (load_s),
        .ready      (dec.out_ready),
        .load_instr (imem_instr),
        .load_pc    ({{(XLEN-PC_W){1'b0}}, pc_r}),
        .valid      (out_valid_s),
        .instr      (dec.out_instr),
        .pc         (dec.out_pc)
    );

    assign dec.out_valid = out_valid_s;
    assign running       = running_r;
    assign fetch_count   = cnt_r;

endmodule

// File: tb/tb_k_fetch_unit.sv
// tb_k_fetch_unit: self-checking bench for k_fetch_unit. A behavioural
// model of the fetch stage (pc, output slot, counter) is advanced once
// per clock from the same inputs; a compare process checks every cycle
// and directed phases pin literal values. A second instance with a
// 2-bit counter exercises counter saturation.
module tb_k_fetch_unit;
    import k_cpu_pkg::*;

`ifdef K_FETCH_HALT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif
    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        ready = 1'b0;
    logic [31:0] imem_addr, imem_addr2, imem_instr, imem_instr2;
    logic        running, running2, halted, halted2;
    logic [31:0] fetch_count;
    logic [1:0]  fetch_count2;
    logic [31:0] mem [0:DEPTH-1];

    int errors = 0;
    int checks = 0;

    // model state: 0 idle, 1 run, 2 halt
    int          m_state;
    int          m_pc;
    bit          m_valid;
    logic [31:0] m_instr;
    int          m_opc;
    longint      m_cnt;

    always #5 clk = ~clk;

    k_fetch_unit_if bus ();
    k_fetch_unit_if bus2 ();
    assign bus.out_ready  = ready;
    assign bus2.out_ready = ready;
    assign imem_instr  = mem[imem_addr[9:0]];
    assign imem_instr2 = mem[imem_addr2[9:0]];

    k_fetch_unit dut (
        .clk(clk), .reset(reset), .start(start),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_addr(imem_addr), .imem_instr(imem_instr), .dec(bus),
        .running(running), .halted(halted), .fetch_count(fetch_count)
    );

    k_fetch_unit #(.CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .start(start),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_addr(imem_addr2), .imem_instr(imem_instr2), .dec(bus2),
        .running(running2), .halted(halted2), .fetch_count(fetch_count2)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_pc = 0; m_valid = 1'b0;
        m_instr = 32'h0; m_opc = 0; m_cnt = 0;
    endtask

    // Next-state of the fetch stage from the rules, applied before the edge.
    task automatic model_step();
        bit acc;
        if (reset) begin
            model_reset();
        end else begin
            acc = m_valid && ready;
            if (acc && m_cnt < 64'hFFFF_FFFF) m_cnt++;
            if (redirect_valid) begin
                m_pc = int'(redirect_pc % 32'd1024);
                m_valid = 1'b0;
                if (m_state == 2) m_state = 1;
            end else if (m_state == 1) begin
                if (!m_valid || ready) begin
                    if (HALT_EN && mem[m_pc] == 32'h0) begin
                        m_state = 2;
                        m_valid = 1'b0;
                    end else begin
                        m_valid = 1'b1;
                        m_instr = mem[m_pc];
                        m_opc   = m_pc;
                        m_pc    = (m_pc + 1) % DEPTH;
                    end
                end
            end else begin
                if (m_state == 0 && start) m_state = 1;
                if (acc) m_valid = 1'b0;
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (!reset) begin
            chk("out_valid", {63'h0, bus.out_valid}, {63'h0, m_valid});
            if (m_valid) begin
                chk("out_instr", {32'h0, bus.out_instr}, {32'h0, m_instr});
                chk("out_pc", {32'h0, bus.out_pc}, 64'(m_opc));
            end
            chk("imem_addr", {32'h0, imem_addr}, 64'(m_pc));
            chk("running", {63'h0, running}, {63'h0, (m_state == 1)});
            chk("halted", {63'h0, halted}, {63'h0, (m_state == 2)});
            chk("fetch_count", {32'h0, fetch_count}, 64'(m_cnt));
            chk("fetch_count2", {62'h0, fetch_count2}, (m_cnt > 3) ? 64'd3 : 64'(m_cnt));
            chk("imem_addr2", {32'h0, imem_addr2}, 64'(m_pc));
        end
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = $urandom() | 32'h1;
        mem[0] = 32'h01; mem[1] = 32'h02; mem[2] = 32'h33;
        model_reset();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;

        // reset values
        chk("rst_out_valid", {63'h0, bus.out_valid}, 64'd0);
        chk("rst_out_instr", {32'h0, bus.out_instr}, 64'd0);
        chk("rst_out_pc", {32'h0, bus.out_pc}, 64'd0);
        chk("rst_imem_addr", {32'h0, imem_addr}, 64'd0);
        chk("rst_running", {63'h0, running}, 64'd0);
        chk("rst_halted", {63'h0, halted}, 64'd0);
        chk("rst_fetch_count", {32'h0, fetch_count}, 64'd0);

        // start and full-throughput fetch of 0x01, 0x02, 0x33
        start = 1'b1; ready = 1'b1;
        tick();
        start = 1'b0;
        chk("start_running", {63'h0, running}, 64'd1);
        chk("start_valid", {63'h0, bus.out_valid}, 64'd0);
        tick();
        chk("f0_pc", {32'h0, bus.out_pc}, 64'd0);
        chk("f0_instr", {32'h0, bus.out_instr}, 64'h01);
        tick();
        chk("f1_pc", {32'h0, bus.out_pc}, 64'd1);
        chk("f1_instr", {32'h0, bus.out_instr}, 64'h02);
        tick();
        chk("f2_pc", {32'h0, bus.out_pc}, 64'd2);
        chk("f2_instr", {32'h0, bus.out_instr}, 64'h33);
        tick();
        chk("cnt_after3", {32'h0, fetch_count}, 64'd3);
        tick(); tick();
        chk("at5_pc", {32'h0, bus.out_pc}, 64'd5);

        // stall at out_pc 5
        ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("stall_pc", {32'h0, bus.out_pc}, 64'd5);
            chk("stall_valid", {63'h0, bus.out_valid}, 64'd1);
            chk("stall_addr", {32'h0, imem_addr}, 64'd6);
            chk("stall_cnt", {32'h0, fetch_count}, 64'd5);
        end

        // redirect while stalled at out_pc 7
        ready = 1'b1;
        tick(); tick();
        chk("at7_pc", {32'h0, bus.out_pc}, 64'd7);
        ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h40;
        tick();
        redirect_valid = 1'b0; ready = 1'b1;
        chk("redir_valid", {63'h0, bus.out_valid}, 64'd0);
        chk("redir_addr", {32'h0, imem_addr}, 64'h40);
        tick();
        chk("redir_pc", {32'h0, bus.out_pc}, 64'h40);
        chk("redir_cnt", {32'h0, fetch_count}, 64'd7);
        chk("sat_cnt2", {62'h0, fetch_count2}, 64'd3);

        // wrap 1022, 1023, 0, 1
        redirect_valid = 1'b1; redirect_pc = 32'd1022;
        tick();
        redirect_valid = 1'b0;
        tick(); chk("wrap_a", {32'h0, bus.out_pc}, 64'd1022);
        tick(); chk("wrap_b", {32'h0, bus.out_pc}, 64'd1023);
        tick(); chk("wrap_c", {32'h0, bus.out_pc}, 64'd0);
        tick(); chk("wrap_d", {32'h0, bus.out_pc}, 64'd1);
        redirect_valid = 1'b1; redirect_pc = 32'h405;
        tick();
        redirect_valid = 1'b0;
        chk("redir_mod", {32'h0, imem_addr}, 64'd5);

        // zero word at address 2
        mem[2] = 32'h0;
        redirect_valid = 1'b1; redirect_pc = 32'h0;
        tick();
        redirect_valid = 1'b0;
        tick(); chk("z_pc0", {32'h0, bus.out_pc}, 64'd0);
        tick(); chk("z_pc1", {32'h0, bus.out_pc}, 64'd1);
        tick();
        if (HALT_EN) begin
            chk("z_halt_valid", {63'h0, bus.out_valid}, 64'd0);
            chk("z_halted", {63'h0, halted}, 64'd1);
            chk("z_addr", {32'h0, imem_addr}, 64'd2);
            tick();
            chk("z_hold_addr", {32'h0, imem_addr}, 64'd2);
        end else begin
            chk("z_issue_pc", {32'h0, bus.out_pc}, 64'd2);
            chk("z_issue_instr", {32'h0, bus.out_instr}, 64'd0);
            chk("z_not_halted", {63'h0, halted}, 64'd0);
        end
        redirect_valid = 1'b1; redirect_pc = 32'h0;
        tick();
        redirect_valid = 1'b0;
        chk("z_resume_run", {63'h0, running}, 64'd1);
        chk("z_resume_addr", {32'h0, imem_addr}, 64'd0);
        tick(); chk("z_resume_pc", {32'h0, bus.out_pc}, 64'd0);

        // randomized traffic with sparse zero words
        for (int i = 0; i < 40; i++) mem[$urandom_range(0, DEPTH - 1)] = 32'h0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 199) == 0) begin
                reset = 1'b1;
                model_reset();
                tick();
                reset = 1'b0;
            end
            start          = ($urandom_range(0, 19) == 0);
            redirect_valid = ($urandom_range(0, 15) == 0);
            redirect_pc    = $urandom();
            ready          = ($urandom_range(0, 3) != 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
